// File: rtl/dff_pipe_chain_pkg.sv
// Shared defaults and elaboration helpers for the D-register pipeline chain.
// Imported by the interface, the stage and the top so all three agree on sizing.
package dff_pipe_chain_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // Occupancy ranges over 0..depth inclusive, hence depth+1 encodings.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_chain_if.sv
// Producer/consumer ready-valid bundle plus occupancy for the pipeline chain.
// The master side drives input data and output ready; the chain is the slave.
interface dff_pipe_chain_if
  import dff_pipe_chain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = cnt_width(DEF_DEPTH)
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/dff_pipe_chain_stage.sv
// One register stage of the chain: a valid bit plus a data word that only
// loads when a valid word arrives, so bubbles never clobber held data.
module dff_pipe_stage
  import dff_pipe_chain_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             adv,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d,  data_q;

  always_comb begin
    // NOTE: every signal gets a hold default first, so no path leaves it unassigned and no latch is inferred.
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (adv) begin
      valid_d = prev_valid;
      if (prev_valid) data_d = prev_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments here so every stage samples its neighbour's pre-edge value.
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/dff_pipe_chain.sv
// Parametrised chain of D-register stages with ready/valid backpressure,
// bubble collapsing, synchronous flush and a registered occupancy count.
module dff_pipe_chain
  import dff_pipe_chain_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  dff_pipe_chain_if.slave  pipe
);

  localparam int CNT_W = cnt_width(DEPTH);

  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] prev_valid;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [WIDTH-1:0] prev_data  [DEPTH];
  logic             in_xfer;
  logic             out_xfer;
  logic [CNT_W-1:0] count_d, count_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    // A stage advances if the consumer takes data or any stage at or after it is empty.
    assign adv[i] = pipe.out_ready | ~(&stage_valid[DEPTH-1:i]);

    if (i == 0) begin : g_head
      assign prev_valid[i] = in_xfer;
      assign prev_data[i]  = pipe.in_data;
    end else begin : g_body
      assign prev_valid[i] = stage_valid[i-1];
      assign prev_data[i]  = stage_data[i-1];
    end

    dff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .adv        (adv[i]),
      .prev_valid (prev_valid[i]),
      .prev_data  (prev_data[i]),
      .valid      (stage_valid[i]),
      .data       (stage_data[i])
    );
  end

  assign pipe.in_ready  = adv[0] & ~flush & reset_n;
  assign in_xfer        = pipe.in_valid & pipe.in_ready;
  assign pipe.out_valid = stage_valid[DEPTH-1];
  assign pipe.out_data  = stage_data[DEPTH-1];
  assign out_xfer       = pipe.out_valid & pipe.out_ready;

  always_comb begin
    count_d = count_q;
    if (flush) count_d = '0;
    else       count_d = count_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign pipe.count = count_q;

endmodule

// File: tb/tb_dff_pipe_chain.sv
// Scenario bench for dff_pipe_chain: a queue of accepted words is compared
// in order against every output handshake, alongside an occupancy model.
module tb_dff_pipe_chain;
  import dff_pipe_chain_pkg::*;

  localparam int               WIDTH     = 8;
  localparam int               DEPTH     = 4;
  localparam int               CNT_W     = cnt_width(DEPTH);
  localparam logic [WIDTH-1:0] RESET_VAL = 8'h5A;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic flush   = 1'b0;

  always #5 clk = ~clk;

  dff_pipe_chain_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  dff_pipe_chain #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (RESET_VAL)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .pipe    (bus.slave)
  );

  logic [WIDTH-1:0] exp_q [$];
  int               model_cnt;
  int               n_checks;
  int               n_fail;
  int               cyc;
  int               first_out_cyc;
  int               last_out_cyc;
  int               out_seen;
  logic             last_in_xfer;
  logic             hold_prev;
  logic             flush_prev;
  logic [WIDTH-1:0] hold_data;

  // One clock: scoreboard and model checks at the falling edge, then step past the rising edge.
  task automatic cycle();
    logic             exp_rdy;
    logic [WIDTH-1:0] exp_w;
    logic             in_x;
    logic             out_x;
    @(negedge clk);
    n_checks++;
    if (bus.count !== CNT_W'(model_cnt)) begin
      n_fail++;
      $display("FAIL count: got %0d expected %0d (cycle %0d)", bus.count, model_cnt, cyc);
    end
    exp_rdy = reset_n && !flush && (bus.out_ready || model_cnt < DEPTH);
    n_checks++;
    if (bus.in_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL in_ready: got %b expected %b (cycle %0d)", bus.in_ready, exp_rdy, cyc);
    end
    if (hold_prev && !flush_prev) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== hold_data) begin
        n_fail++;
        $display("FAIL stall_hold: got v=%b d=%h expected v=1 d=%h", bus.out_valid, bus.out_data, hold_data);
      end
    end
    in_x  = bus.in_valid && bus.in_ready;
    out_x = bus.out_valid && bus.out_ready;
    if (out_x) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_data: got unexpected word %h expected none", bus.out_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (bus.out_data !== exp_w) begin
          n_fail++;
          $display("FAIL out_data: got %h expected %h", bus.out_data, exp_w);
        end
      end
      if (first_out_cyc < 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
      out_seen++;
    end
    if (flush) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      if (in_x) exp_q.push_back(bus.in_data);
      model_cnt = model_cnt + int'(in_x) - int'(out_x);
    end
    last_in_xfer = in_x;
    hold_prev    = bus.out_valid && !bus.out_ready;
    hold_data    = bus.out_data;
    flush_prev   = flush;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_marks();
    first_out_cyc = -1;
    last_out_cyc  = -1;
    out_seen      = 0;
  endtask

  task automatic drain(input int budget);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (exp_q.size() > 0 && budget > 0) begin
      cycle();
      budget--;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
    end
    repeat (2) cycle();
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h77;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks += 4;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    if (bus.out_data !== RESET_VAL) begin
      n_fail++; $display("FAIL reset_out_data: got %h expected %h", bus.out_data, RESET_VAL);
    end
    if (bus.count !== '0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count);
    end
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    reset_n      = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic test_stream();
    int start;
    reset_marks();
    bus.out_ready = 1'b1;
    start = cyc;
    for (int k = 1; k <= 16; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = WIDTH'(k);
      cycle();
    end
    drain(20);
    n_checks += 3;
    if (out_seen != 16) begin
      n_fail++; $display("FAIL stream_count: got %0d words expected 16", out_seen);
    end
    if (first_out_cyc - start != DEPTH) begin
      n_fail++; $display("FAIL stream_latency: got %0d cycles expected %0d", first_out_cyc - start, DEPTH);
    end
    if (last_out_cyc - first_out_cyc != 15) begin
      n_fail++; $display("FAIL stream_rate: got span %0d expected 15", last_out_cyc - first_out_cyc);
    end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    reset_marks();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = WIDTH'(accepted + 1);
      cycle();
      if (last_in_xfer) accepted++;
    end
    n_checks += 3;
    if (accepted != DEPTH) begin
      n_fail++; $display("FAIL bp_accepted: got %0d expected %0d", accepted, DEPTH);
    end
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready);
    end
    if (bus.count !== CNT_W'(DEPTH)) begin
      n_fail++; $display("FAIL bp_count: got %0d expected %0d", bus.count, DEPTH);
    end
    drain(10);
    n_checks++;
    if (out_seen != DEPTH) begin
      n_fail++; $display("FAIL bp_drained: got %0d words expected %0d", out_seen, DEPTH);
    end
  endtask

  task automatic test_bubbles();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      bus.in_valid = (k == 0) || (k == 3);
      bus.in_data  = (k == 0) ? 8'hB1 : 8'hB2;
      cycle();
    end
    n_checks += 3;
    if (bus.count !== CNT_W'(2)) begin
      n_fail++; $display("FAIL bubble_count: got %0d expected 2", bus.count);
    end
    if (dut.stage_valid !== 4'b1100) begin
      n_fail++; $display("FAIL bubble_valids: got %b expected 1100", dut.stage_valid);
    end
    if (dut.stage_data[3] !== 8'hB1 || dut.stage_data[2] !== 8'hB2) begin
      n_fail++;
      $display("FAIL bubble_data: got %h/%h expected b1/b2", dut.stage_data[3], dut.stage_data[2]);
    end
    drain(10);
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = WIDTH'(8'hC1 + k);
      cycle();
    end
    flush         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hEE;
    bus.out_ready = 1'b1;
    cycle();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    n_checks += 2;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_out_valid: got %b expected 0", bus.out_valid);
    end
    if (bus.count !== '0) begin
      n_fail++; $display("FAIL flush_count: got %0d expected 0", bus.count);
    end
    repeat (DEPTH + 2) cycle();
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = WIDTH'(8'hD0 + k);
      cycle();
    end
    bus.in_valid = 1'b0;
    #2;
    n_checks++;
    if (bus.count !== CNT_W'(3)) begin
      n_fail++; $display("FAIL arst_precount: got %0d expected 3", bus.count);
    end
    reset_n = 1'b0;
    #1;
    n_checks += 4;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL arst_out_valid: got %b expected 0", bus.out_valid);
    end
    if (bus.count !== '0) begin
      n_fail++; $display("FAIL arst_count: got %0d expected 0", bus.count);
    end
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL arst_in_ready: got %b expected 0", bus.in_ready);
    end
    if (bus.out_data !== RESET_VAL) begin
      n_fail++; $display("FAIL arst_out_data: got %h expected %h", bus.out_data, RESET_VAL);
    end
    exp_q.delete();
    model_cnt = 0;
    hold_prev = 1'b0;
    @(posedge clk);
    #1;
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hD9;
    cycle();
    drain(10);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    cyc          = 0;
    model_cnt    = 0;
    hold_prev    = 1'b0;
    flush_prev   = 1'b0;
    last_in_xfer = 1'b0;
    hold_data    = '0;
    reset_marks();
    test_reset();
    test_stream();
    test_backpressure();
    test_bubbles();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
